// File: rtl/multicycle_control_fsm.sv
// Control FSM for a multicycle RV32 subset datapath: sequences fetch, decode,
// execute, memory and writeback steps and counts retired instructions.
module multicycle_control_fsm (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        adr_src,
   output logic        pc_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        is_imm,
   output logic [2:0]  imm_src,
   output logic        trap,
   output logic [31:0] retired
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_PC,
      S_LUI, S_TRAP
   } state_t;

   state_t      r_state;
   logic [31:0] r_retired;
   logic        w_br_ok;
   logic        w_br_taken;
   logic        w_retire;

   assign w_br_ok    = (funct3 == 3'b000) || (funct3 == 3'b001);
   assign w_br_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

   // An instruction retires on the edge that returns the FSM to FETCH.
   assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                     ((r_state == S_MEMWRITE) && mem_ready) ||
                     ((r_state == S_BRANCH) && w_br_ok);

   assign retired = r_retired;
   assign trap    = (r_state == S_TRAP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_retired <= 32'd0;
      end else begin
         if (w_retire) begin
            r_retired <= r_retired + 32'd1;
         end
         case (r_state)
            S_FETCH:    if (mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                  OP_R:              r_state <= S_EXECR;
                  OP_I:              r_state <= S_EXECI;
                  OP_BR:             r_state <= S_BRANCH;
                  OP_JAL:            r_state <= S_JAL;
                  OP_JALR:           r_state <= S_JALR;
                  OP_LUI:            r_state <= S_LUI;
                  default:           r_state <= S_TRAP;
               endcase
            end
            S_MEMADR:   r_state <= (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
            S_MEMWB:    r_state <= S_FETCH;
            S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
            S_EXECR:    r_state <= S_ALUWB;
            S_EXECI:    r_state <= S_ALUWB;
            S_ALUWB:    r_state <= S_FETCH;
            S_BRANCH:   r_state <= w_br_ok ? S_FETCH : S_TRAP;
            S_JAL:      r_state <= S_ALUWB;
            S_JALR:     r_state <= S_JALR_PC;
            S_JALR_PC:  r_state <= S_ALUWB;
            S_LUI:      r_state <= S_ALUWB;
            S_TRAP:     r_state <= S_TRAP;
            default:    r_state <= S_TRAP;
         endcase
      end
   end

   // Outputs are masked while rst_n is low so FETCH does not strobe memory in reset.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      is_imm     = 1'b0;
      imm_src    = 3'b000;
      if (rst_n) begin
         case (r_state)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_write   = 1'b1;
                  pc_write   = 1'b1;
                  alu_src_b  = 2'b10;
                  result_src = 2'b10;
               end
            end
            S_DECODE: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
               imm_src   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
            end
            S_MEMADR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               imm_src   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
               mem_req = 1'b1;
               adr_src = 1'b1;
            end
            S_MEMWB: begin
               result_src = 2'b01;
               reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               adr_src = 1'b1;
            end
            S_EXECR: begin
               alu_src_a = 2'b10;
               alu_op    = 2'b10;
            end
            S_EXECI: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               alu_op    = 2'b11;
               is_imm    = 1'b1;
            end
            S_ALUWB:  reg_write = 1'b1;
            S_BRANCH: begin
               alu_src_a = 2'b10;
               alu_op    = 2'b01;
               pc_write  = w_br_taken;
            end
            S_JAL, S_JALR_PC: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
               pc_write  = 1'b1;
            end
            S_JALR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
            end
            S_LUI: begin
               alu_src_a = 2'b11;
               alu_src_b = 2'b01;
               imm_src   = 3'b100;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected control sequences
// are built from the instruction class and compared cycle by cycle.
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, mem_we, adr_src, pc_write, ir_write, reg_write;
   logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
   logic        is_imm;
   logic [2:0]  imm_src;
   logic        trap;
   logic [31:0] retired;

   multicycle_control_fsm dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
      .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .is_imm(is_imm), .imm_src(imm_src), .trap(trap), .retired(retired)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   typedef struct packed {
      logic        mr;
      logic [18:0] cw;
   } step_t;

   step_t       exp_q[$];
   logic [18:0] dut_cw;
   logic [31:0] model_ret;
   int          n_checks = 0;
   int          n_pass   = 0;

   assign dut_cw = {mem_req, mem_we, adr_src, pc_write, ir_write, reg_write,
                    result_src, alu_src_a, alu_src_b, alu_op, is_imm, imm_src, trap};

   function automatic logic [18:0] cw(input logic mreq, input logic mwe, input logic adr,
                                      input logic pcw, input logic irw, input logic rw,
                                      input logic [1:0] rs, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] aop,
                                      input logic imm, input logic [2:0] isrc, input logic tr);
      return {mreq, mwe, adr, pcw, irw, rw, rs, a, b, aop, imm, isrc, tr};
   endfunction

   function automatic step_t st(input logic mr, input logic [18:0] c);
      return {mr, c};
   endfunction

   function automatic logic rbit();
      return logic'($urandom_range(0, 1));
   endfunction

   // Expected control words for one whole instruction, starting in FETCH.
   task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic z,
                        input int wf, input int wm, output logic retires);
      logic [18:0] alu_wb;
      logic [18:0] to_pc;
      logic [18:0] trap_cw;
      alu_wb  = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,2'd0,2'd0,1'b0,3'd0,1'b0);
      to_pc   = cw(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,2'd1,2'd2,2'd0,1'b0,3'd0,1'b0);
      trap_cw = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,3'd0,1'b1);
      exp_q.delete();
      retires = 1'b1;
      for (int i = 0; i < wf; i++)
         exp_q.push_back(st(1'b0, cw(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,3'd0,1'b0)));
      exp_q.push_back(st(1'b1, cw(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'd2,2'd0,2'd2,2'd0,1'b0,3'd0,1'b0)));
      exp_q.push_back(st(rbit(), cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,2'd0,1'b0,
                                    (op == OP_JAL) ? 3'd3 : 3'd2, 1'b0)));
      case (op)
         OP_R: begin
            exp_q.push_back(st(rbit(), cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,2'd2,1'b0,3'd0,1'b0)));
            exp_q.push_back(st(rbit(), alu_wb));
         end
         OP_I: begin
            exp_q.push_back(st(rbit(), cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,2'd3,1'b1,3'd0,1'b0)));
            exp_q.push_back(st(rbit(), alu_wb));
         end
         OP_LUI: begin
            exp_q.push_back(st(rbit(), cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd3,2'd1,2'd0,1'b0,3'd4,1'b0)));
            exp_q.push_back(st(rbit(), alu_wb));
         end
         OP_JAL: begin
            exp_q.push_back(st(rbit(), to_pc));
            exp_q.push_back(st(rbit(), alu_wb));
         end
         OP_JALR: begin
            exp_q.push_back(st(rbit(), cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,2'd0,1'b0,3'd0,1'b0)));
            exp_q.push_back(st(rbit(), to_pc));
            exp_q.push_back(st(rbit(), alu_wb));
         end
         OP_LOAD, OP_STORE: begin
            logic       is_st;
            logic [18:0] mem_cw;
            is_st  = (op == OP_STORE);
            mem_cw = cw(1'b1,is_st,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,3'd0,1'b0);
            exp_q.push_back(st(rbit(), cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,2'd0,1'b0,
                                          {2'b00, is_st}, 1'b0)));
            for (int i = 0; i < wm; i++) exp_q.push_back(st(1'b0, mem_cw));
            exp_q.push_back(st(1'b1, mem_cw));
            if (!is_st)
               exp_q.push_back(st(rbit(), cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,2'd0,2'd0,2'd0,1'b0,3'd0,1'b0)));
         end
         OP_BR: begin
            logic taken;
            logic ok;
            ok    = (f3 == 3'b000) || (f3 == 3'b001);
            taken = ((f3 == 3'b000) && z) || ((f3 == 3'b001) && !z);
            exp_q.push_back(st(rbit(), cw(1'b0,1'b0,1'b0,taken,1'b0,1'b0,2'd0,2'd2,2'd0,2'd1,1'b0,3'd0,1'b0)));
            if (!ok) begin
               retires = 1'b0;
               for (int i = 0; i < 10; i++) exp_q.push_back(st(rbit(), trap_cw));
            end
         end
         default: begin
            retires = 1'b0;
            for (int i = 0; i < 10; i++) exp_q.push_back(st(rbit(), trap_cw));
         end
      endcase
   endtask

   task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic z, input int wf, input int wm);
      logic  retires;
      int    bad;
      int    cyc;
      bad = 0;
      build(op, f3, z, wf, wm, retires);
      cyc = exp_q.size();
      foreach (exp_q[i]) begin
         @(negedge clk);
         opcode    = op;
         funct3    = f3;
         zero      = z;
         mem_ready = exp_q[i].mr;
         #1;
         n_checks++;
         if (dut_cw !== exp_q[i].cw) begin
            bad++;
            $display("FAIL %s cycle %0d: control word got %05h expected %05h", name, i, dut_cw, exp_q[i].cw);
         end else n_pass++;
      end
      if (retires) model_ret = model_ret + 32'd1;
      @(posedge clk);
      #1;
      n_checks++;
      if (retired !== model_ret) begin
         bad++;
         $display("FAIL %s retired: got %08h expected %08h", name, retired, model_ret);
      end else n_pass++;
      $display("instr %-6s op=%07b f3=%03b z=%0b wf=%0d wm=%0d cycles=%0d retired=%08h errors=%0d",
               name, op, f3, z, wf, wm, cyc, retired, bad);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({dut_cw, retired} !== 51'd0) begin
         $display("FAIL reset: cw=%05h retired=%08h expected all zero", dut_cw, retired);
      end else n_pass++;
      model_ret = 32'd0;
      @(negedge clk);
      rst_n     = 1'b1;
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (dut_cw !== cw(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,3'd0,1'b0)) begin
         $display("FAIL first_fetch: cw=%05h expected fetch request", dut_cw);
      end else n_pass++;
      $display("reset  released, fetch request cw=%05h", dut_cw);
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({dut_cw, retired} !== 51'd0) begin
         $display("FAIL reset_initial: cw=%05h retired=%08h expected all zero", dut_cw, retired);
      end else n_pass++;
      apply_reset();
   endtask

   task automatic test_directed();
      run_instr("ADD",  OP_R,   3'b000, 1'b0, 0, 0);
      run_instr("LW",   OP_LOAD,3'b010, 1'b0, 0, 3);
      run_instr("SW",   OP_STORE,3'b010,1'b0, 2, 1);
      run_instr("BEQ",  OP_BR,  3'b000, 1'b1, 0, 0);
      run_instr("BNE",  OP_BR,  3'b001, 1'b1, 0, 0);
      run_instr("BNE",  OP_BR,  3'b001, 1'b0, 1, 0);
      run_instr("JAL",  OP_JAL, 3'b000, 1'b0, 0, 0);
      run_instr("JALR", OP_JALR,3'b000, 1'b0, 0, 0);
      run_instr("LUI",  OP_LUI, 3'b000, 1'b0, 0, 0);
      run_instr("ADDI", OP_I,   3'b000, 1'b0, 0, 0);
   endtask

   task automatic test_trap();
      run_instr("ILL", 7'b1111111, 3'b000, 1'b0, 0, 0);
      apply_reset();
      run_instr("BADBR", OP_BR, 3'b100, 1'b0, 0, 0);
      apply_reset();
   endtask

   task automatic test_reset_in_memwrite();
      run_instr("ADD", OP_R, 3'b000, 1'b0, 0, 0);
      @(negedge clk); opcode = OP_STORE; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); mem_ready = 1'b0;
      #1;
      n_checks++;
      if (mem_we !== 1'b1) $display("FAIL memwrite_wait: mem_we=%0b expected 1", mem_we);
      else n_pass++;
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({mem_we, mem_req, retired} !== 34'd0) begin
         $display("FAIL reset_in_memwrite: mem_we=%0b mem_req=%0b retired=%08h expected 0", mem_we, mem_req, retired);
      end else n_pass++;
      model_ret = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (dut_cw !== cw(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,3'd0,1'b0)) begin
         $display("FAIL restart_fetch: cw=%05h expected fetch request", dut_cw);
      end else n_pass++;
      $display("reset  during store wait, restart cw=%05h retired=%08h", dut_cw, retired);
   endtask

   task automatic test_wrap();
      @(negedge clk);
      mem_ready = 1'b0;
      force dut.r_retired = 32'hFFFF_FFFF;
      #1;
      release dut.r_retired;
      model_ret = 32'hFFFF_FFFF;
      #1;
      n_checks++;
      if (retired !== model_ret) $display("FAIL preload: retired=%08h expected %08h", retired, model_ret);
      else n_pass++;
      run_instr("ADDI", OP_I, 3'b000, 1'b0, 0, 0);
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops [8];
      ops = '{OP_R, OP_I, OP_LUI, OP_JAL, OP_JALR, OP_LOAD, OP_STORE, OP_BR};
      for (int n = 0; n < 30; n++) begin
         logic [6:0] op;
         logic [2:0] f3;
         op = ops[$urandom_range(0, 7)];
         f3 = (op == OP_BR) ? {2'b00, rbit()} : 3'($urandom_range(0, 7));
         run_instr("RAND", op, f3, rbit(), $urandom_range(0, 2), $urandom_range(0, 3));
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      opcode    = 7'd0;
      funct3    = 3'd0;
      zero      = 1'b0;
      mem_ready = 1'b0;
      model_ret = 32'd0;
      test_reset();
      test_directed();
      test_trap();
      test_reset_in_memwrite();
      test_wrap();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 Block SHALL have no parameters; all encodings fixed below.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 opcode  in  7  instruction[6:0] from IR; valid from DECODE onward.
REQ-005 funct3  in  3  instruction[14:12].
REQ-006 zero  in  1  ALU zero flag, same cycle as ALU result.
REQ-007 mem_ready  in  1  memory completes the current mem_req this cycle.
REQ-008 mem_req, mem_we, adr_src  out  1 each  memory strobe, write enable, address select (0=PC, 1=alu_out).
REQ-009 pc_write, ir_write, reg_write  out  1 each  PC, IR, register-file write enables.
REQ-010 result_src  out  2  00=alu_out reg, 01=mem data, 10=ALU result direct.
REQ-011 alu_src_a  out  2  00=PC, 01=old_pc, 10=rs1, 11=zero.
REQ-012 alu_src_b  out  2  00=rs2, 01=immediate, 10=constant 4.
REQ-013 alu_op  out  2  to ALU decoder: 00=add, 01=sub, 10=R-type, 11=I-type.
REQ-014 is_imm  out  1  to ALU decoder; 1 only in EXECI.
REQ-015 imm_src  out  3  000=I, 001=S, 010=B, 011=J, 100=U.
REQ-016 trap  out  1  sticky illegal-instruction indicator.
REQ-017 retired  out  32  count of completed instructions.

Function
REQ-018 Outputs SHALL be decoded from current state (plus mem_ready/zero/funct3 where stated); any output not listed for a state SHALL be 0.
REQ-019 FETCH: mem_req=1, adr_src=0; when mem_ready=1: ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, next DECODE; else hold FETCH with all write enables 0.
REQ-020 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00, imm_src=011 if opcode=1101111 else 010; next by opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, other->TRAP.
REQ-021 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00, imm_src=000 for load, 001 for store; next MEMREAD (load) or MEMWRITE (store).
REQ-022 MEMREAD: mem_req=1, adr_src=1; hold until mem_ready=1, then MEMWB.
REQ-023 MEMWB: result_src=01, reg_write=1; next FETCH.
REQ-024 MEMWRITE: mem_req=1, mem_we=1, adr_src=1; hold until mem_ready=1, then FETCH.
REQ-025 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, is_imm=0; next ALUWB.
REQ-026 EXECI: alu_src_a=10, alu_src_b=01, imm_src=000, alu_op=11, is_imm=1; next ALUWB.
REQ-027 ALUWB: result_src=00, reg_write=1; next FETCH.
REQ-028 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00; pc_write=(funct3=000 & zero)|(funct3=001 & ~zero); next FETCH; funct3 not 000/001 -> TRAP, pc_write=0.
REQ-029 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1; next ALUWB.
REQ-030 JALR: alu_src_a=10, alu_src_b=01, imm_src=000, alu_op=00; next JALR_PC.
REQ-031 JALR_PC: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1; next ALUWB.
REQ-032 LUI: alu_src_a=11, alu_src_b=01, imm_src=100, alu_op=00; next ALUWB.
REQ-033 TRAP: trap=1, all enables 0; state held until reset.
REQ-034 retired SHALL increment by 1 (mod 2^32, wraps to 0) on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
REQ-035 Latency in cycles with mem_ready=1 in first cycle: R/I/LUI/JAL=4, load=5, store=4, branch=3, JALR=5.

Reset
REQ-036 rst_n=0 SHALL immediately force state FETCH, retired=0, trap=0, all write enables and mem_req to 0, regardless of mem wait state.
REQ-037 First FETCH request SHALL occur in the first cycle with rst_n=1.

Verification
REQ-038 R-type ADD, opcode=0110011, mem_ready=1 -> FETCH,DECODE,EXECR(alu_op=10,is_imm=0),ALUWB(reg_write=1), retired=1.
REQ-039 Load with mem_ready low 3 cycles in MEMREAD -> mem_req=1, adr_src=1 held 4 cycles, reg_write pulses once in MEMWB.
REQ-040 BEQ zero=1 -> pc_write=1 in BRANCH; BNE zero=1 -> pc_write=0; both return to FETCH, retired+1.
REQ-041 opcode=1111111 -> TRAP next cycle, trap=1 persists 10 cycles, no enable asserted; rst_n low clears.
REQ-042 rst_n asserted during MEMWRITE wait -> mem_we drops same cycle, restart in FETCH, retired=0.
REQ-043 Preload retired=FFFFFFFF via 2^32-equivalent force, complete one ADDI -> retired=00000000.
